// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore sequencer driving the 8-bit data_path register enables and bus selects
module control_unit (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic [2:0] ALU_Sel,
  output logic       write
);

  localparam logic [7:0] LDA_IMM = 8'h86;
  localparam logic [7:0] LDA_DIR = 8'h87;
  localparam logic [7:0] LDB_IMM = 8'h88;
  localparam logic [7:0] LDB_DIR = 8'h89;
  localparam logic [7:0] STA_DIR = 8'h96;
  localparam logic [7:0] STB_DIR = 8'h97;
  localparam logic [7:0] ADD_AB  = 8'h42;
  localparam logic [7:0] SUB_AB  = 8'h43;
  localparam logic [7:0] AND_AB  = 8'h44;
  localparam logic [7:0] OR_AB   = 8'h45;
  localparam logic [7:0] BRA     = 8'h20;
  localparam logic [7:0] BEQ     = 8'h23;
  localparam logic [7:0] BNE     = 8'h24;

  localparam logic [1:0] B1_PC  = 2'b00;
  localparam logic [1:0] B1_A   = 2'b01;
  localparam logic [1:0] B1_B   = 2'b10;
  localparam logic [1:0] B2_ALU = 2'b00;
  localparam logic [1:0] B2_B1  = 2'b01;
  localparam logic [1:0] B2_MEM = 2'b10;

  // Wider than needed so that stray encodings exist and fall back to fetch
  typedef enum logic [3:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3,
    S4 = 4'd4, S5 = 4'd5, S6 = 4'd6, S7 = 4'd7
  } state_t;

  state_t state;
  state_t next_state;

  logic is_ld_imm;
  logic is_ld_dir;
  logic is_st_dir;
  logic is_alu;
  logic is_branch;
  logic is_known;
  logic br_taken;

  // Only Z steers the sequencer; N, V and C are carried for the data_path alone
  logic unused_flags;
  assign unused_flags = ^{CCR_Result[3], CCR_Result[1:0]};

  // Instruction class decode from the held IR
  assign is_ld_imm = (IR == LDA_IMM) || (IR == LDB_IMM);
  assign is_ld_dir = (IR == LDA_DIR) || (IR == LDB_DIR);
  assign is_st_dir = (IR == STA_DIR) || (IR == STB_DIR);
  assign is_alu    = (IR == ADD_AB) || (IR == SUB_AB) || (IR == AND_AB) || (IR == OR_AB);
  assign is_branch = (IR == BRA) || (IR == BEQ) || (IR == BNE);
  assign is_known  = is_ld_imm || is_ld_dir || is_st_dir || is_alu || is_branch;
  assign br_taken  = (IR == BRA) ||
                     ((IR == BEQ) && CCR_Result[2]) ||
                     ((IR == BNE) && !CCR_Result[2]);

  // State register; reset drops straight back to fetch even mid-instruction
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S0;
    end else begin
      state <= next_state;
    end
  end

  // Next-state sequencing per instruction class
  always_comb begin
    next_state = S0;
    unique case (state)
      S0: next_state = S1;
      S1: next_state = S2;
      S2: next_state = S3;
      S3: next_state = is_known ? S4 : S0;
      S4: next_state = (is_alu || !is_known) ? S0 : S5;
      S5: next_state = (is_ld_dir || is_st_dir) ? S6 : S0;
      S6: next_state = S7;
      S7: next_state = S0;
      default: next_state = S0;
    endcase
  end

  // Moore output decode; CCR_Result reaches the outputs only through the S5 branch decision
  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    CCR_Load = 1'b0;
    write    = 1'b0;
    Bus1_Sel = B1_PC;
    Bus2_Sel = B2_ALU;
    ALU_Sel  = 3'b000;
    unique case (state)
      S0: begin
        Bus1_Sel = B1_PC;
        Bus2_Sel = B2_B1;
        MAR_Load = 1'b1;
      end
      S1: PC_Inc = 1'b1;
      S2: begin
        Bus2_Sel = B2_MEM;
        IR_Load  = 1'b1;
      end
      S3: ;
      S4: begin
        if (is_alu) begin
          Bus2_Sel = B2_ALU;
          A_Load   = 1'b1;
          CCR_Load = 1'b1;
          unique case (IR)
            SUB_AB:  ALU_Sel = 3'b001;
            AND_AB:  ALU_Sel = 3'b010;
            OR_AB:   ALU_Sel = 3'b011;
            default: ALU_Sel = 3'b000;
          endcase
        end else if (is_known) begin
          // Point MAR at the operand byte
          Bus1_Sel = B1_PC;
          Bus2_Sel = B2_B1;
          MAR_Load = 1'b1;
        end
      end
      S5: begin
        if (is_ld_imm) begin
          Bus2_Sel = B2_MEM;
          A_Load   = (IR == LDA_IMM);
          B_Load   = (IR == LDB_IMM);
          PC_Inc   = 1'b1;
        end else if (is_branch && br_taken) begin
          Bus2_Sel = B2_MEM;
          PC_Load  = 1'b1;
        end else if (is_known) begin
          // Direct ops and untaken branches step over the operand
          PC_Inc = 1'b1;
        end
      end
      S6: begin
        if (is_ld_dir || is_st_dir) begin
          Bus2_Sel = B2_MEM;
          MAR_Load = 1'b1;
        end
      end
      S7: begin
        if (is_ld_dir) begin
          Bus2_Sel = B2_MEM;
          A_Load   = (IR == LDA_DIR);
          B_Load   = (IR == LDB_DIR);
        end else if (is_st_dir) begin
          Bus1_Sel = (IR == STA_DIR) ? B1_A : B1_B;
          write    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; opcodes and ALU_Sel codes are fixed per REQ-010 and REQ-011.
REQ-002 Clk  in  1  sole clock, rising edge.
REQ-003 Reset  in  1  asynchronous, active-low.
REQ-004 IR  in  8  current instruction register value from data_path.
REQ-005 CCR_Result  in  4  flags {N,Z,V,C}, bit3=N, bit2=Z, bit1=V, bit0=C.
REQ-006 IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load  out  1 each  data_path register enables.
REQ-007 Bus1_Sel  out  2  bus1 source: 00=PC, 01=A, 10=B.
REQ-008 Bus2_Sel  out  2  bus2 source: 00=ALU, 01=Bus1, 10=from_memory.
REQ-009 ALU_Sel  out  3  ALU op; write  out  1  memory write strobe (data=Bus1, addr=MAR).

Function
REQ-010 Opcodes SHALL be: LDA_IMM 86, LDA_DIR 87, LDB_IMM 88, LDB_DIR 89, STA_DIR 96, STB_DIR 97, ADD_AB 42, SUB_AB 43, AND_AB 44, OR_AB 45, BRA 20, BEQ 23, BNE 24 (hex).
REQ-011 ALU_Sel SHALL be 000 for ADD, 001 for SUB, 010 for AND, 011 for OR, and 000 in all other states.
REQ-012 The block SHALL be a Moore FSM; outputs decode from the state register plus IR only, with no combinational path from CCR_Result to outputs except in branch-decision states.
REQ-013 Outputs not asserted by a state SHALL be 0; Bus1_Sel and Bus2_Sel SHALL default to 00.
REQ-014 Memory reads are combinational: from_memory is valid in the same cycle as MAR.
REQ-015 The fetch sequence SHALL be:
- S0: Bus1=PC, Bus2=Bus1, MAR_Load.
- S1: PC_Inc (PC<=MAR+1).
- S2: Bus2=mem, IR_Load.
- S3: decode; no enables asserted.
REQ-016 Immediate loads SHALL be:
- S4: MAR<=PC.
- S5: Bus2=mem, A_Load or B_Load, PC_Inc.
- Then S0.
REQ-017 Direct loads SHALL be:
- S4: MAR<=PC.
- S5: PC_Inc.
- S6: Bus2=mem, MAR_Load.
- S7: Bus2=mem, A_Load or B_Load.
- Then S0.
REQ-018 Direct stores SHALL follow S4-S6 as in REQ-017, then S7: Bus1=A (STA) or B (STB), write=1 for exactly one cycle; then S0.
REQ-019 ALU ops SHALL take a single S4: Bus2=ALU, ALU_Sel per REQ-011, A_Load and CCR_Load together; then S0.
REQ-020 Branches SHALL start with S4: MAR<=PC.
- Taken (BRA always; BEQ when Z=1; BNE when Z=0): S5 is Bus2=mem, PC_Load.
- Not taken: S5 is PC_Inc, skipping the operand.
- Z SHALL be sampled in S5.
- Then S0.
REQ-021 An unknown opcode SHALL return from S3 to S0 (NOP); PC has already advanced by 1.
REQ-022 PC_Load and PC_Inc SHALL never be asserted in the same cycle; write SHALL never coincide with any load enable.
REQ-023 Instruction latency SHALL be: ALU 5 cycles, imm load 6, branch 6, direct load/store 8, NOP 4.
REQ-024 Unused state encodings SHALL transition to S0 on the next edge.

Reset
REQ-025 Reset low SHALL force the state to S0 asynchronously, at any point including mid-instruction.
REQ-026 While Reset is low, outputs SHALL equal the S0 decode: MAR_Load=1, Bus1_Sel=00, Bus2_Sel=01, all other outputs 0.
REQ-027 After Reset goes high, the first rising edge SHALL execute S0 (fetch from PC=00).

Verification
REQ-028 mem[00]=86, mem[01]=0A, then reset and run -> A=0A after 6 cycles, PC=02, no write pulse observed.
REQ-029 Program LDA_IMM 05, LDB_IMM 03, SUB_AB -> A=02, CCR=0000, CCR_Load high exactly 1 cycle with ALU_Sel=001.
REQ-030 A=7F, STA_DIR to address 40 -> mem[40]=7F, write high 1 cycle in S7 with MAR=40 and Bus1_Sel=01.
REQ-031 BEQ 10 with Z=1 -> PC=10; the same branch with Z=0 -> PC = branch address+2; BRA always taken.
REQ-032 Opcode FF -> back in S0 after 4 cycles with A, B, CCR unchanged; Reset pulsed low in S6 of LDA_DIR -> S0 immediately, A unchanged.
REQ-033 Every cycle of every test SHALL be checked against REQ-022 (no PC_Load with PC_Inc, no write with any load enable).
